// File: rtl/xbar_pkg.sv
// Shared crossbar package: default geometry and the index-width helper.
package xbar_pkg;

    localparam int XBAR_N_DEFAULT = 4;
    localparam int XBAR_W_DEFAULT = 8;

    // Ceiling log2, never below 1 so a 2-port crossbar still gets a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Per-output arbiter: N request bits in, one-hot grant out.
// Build option XBAR_RR_EN: defined -> round-robin with an internal pointer,
// undefined -> fixed priority (lowest index wins), no pointer state.
module xbar_rr_arbiter
    import xbar_pkg::*;
#(
    parameter int N = XBAR_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int S = clog2(N);

`ifdef XBAR_RR_EN
    logic [S-1:0] ptr_q;
    logic [S-1:0] ptr_d;

    // Search from the pointer upward with wrap; winner's successor becomes the new pointer.
    always_comb begin
        logic         found;
        int           idx_i;
        logic [S-1:0] idx;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx_i = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= N) begin
                idx_i = idx_i - N;
            end
            idx = S'(idx_i);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = (idx_i == N - 1) ? '0 : S'(idx_i + 1);
            end
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
            end
        end
    end

    // Clock and reset are unused without pointer state.
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;
`endif

endmodule

// File: rtl/crossbar_nxn_rr.sv
// N x N crossbar with one arbiter per output and registered output stages.
// Build option XBAR_RR_EN selects round-robin (defined) or fixed priority
// (undefined) arbitration inside xbar_rr_arbiter.
module crossbar_nxn_rr
    import xbar_pkg::*;
#(
    parameter int N = XBAR_N_DEFAULT,
    parameter int W = XBAR_W_DEFAULT,
    localparam int S = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*S-1:0] in_dest,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic [N-1:0]   out_valid,
    output logic [N*W-1:0] out_data,
    output logic [N*S-1:0] out_src,
    input  logic [N-1:0]   out_ready,
    output logic           err_drop
);

    // req[j][i] / gnt[j][i]: input i targeting / granted on output j.
    logic [N-1:0][N-1:0] req;
    logic [N-1:0][N-1:0] gnt;
    logic [N-1:0]        free;
    logic [N-1:0]        illegal;

    logic [N-1:0]   out_valid_q, out_valid_d;
    logic [N*W-1:0] out_data_q,  out_data_d;
    logic [N*S-1:0] out_src_q,   out_src_d;
    logic           err_drop_q,  err_drop_d;

    // Decode destinations into per-output request vectors; flag out-of-range ones.
    always_comb begin
        logic [S-1:0] dest;
        req     = '0;
        illegal = '0;
        dest    = '0;
        for (int i = 0; i < N; i++) begin
            dest       = in_dest[i*S +: S];
            illegal[i] = rst_n && in_valid[i] && ({1'b0, dest} >= (S+1)'(N));
            for (int j = 0; j < N; j++) begin
                req[j][i] = rst_n && in_valid[i] && (dest == S'(j));
            end
        end
    end

    // An output can accept when empty or being drained this cycle.
    always_comb begin
        free = '0;
        for (int j = 0; j < N; j++) begin
            free[j] = !out_valid_q[j] || out_ready[j];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_arb
        xbar_rr_arbiter #(.N(N)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req[j]),
            .en    (free[j]),
            .gnt   (gnt[j])
        );
    end

    // Accept an input when granted somewhere, or unconditionally when its destination is illegal.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = illegal[i];
            for (int j = 0; j < N; j++) begin
                in_ready[i] = in_ready[i] | gnt[j][i];
            end
        end
    end

    // Output stage next state: load on grant, clear on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        err_drop_d  = |illegal;
        for (int j = 0; j < N; j++) begin
            if (|gnt[j]) begin
                out_valid_d[j] = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (gnt[j][i]) begin
                        out_data_d[j*W +: W] = in_data[i*W +: W];
                        out_src_d[j*S +: S]  = S'(i);
                    end
                end
            end else if (out_ready[j]) begin
                out_valid_d[j] = 1'b0;
            end
        end
    end

    // Output and error registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_crossbar_nxn_rr.sv
// Directed bench for crossbar_nxn_rr (N=4, W=8) plus an N=3 instance for illegal destinations.
module tb_crossbar_nxn_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int N3 = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*S-1:0] in_dest;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   out_valid;
    logic [N*W-1:0] out_data;
    logic [N*S-1:0] out_src;
    logic [N-1:0]   out_ready;
    logic           err_drop;

    logic [N3-1:0]   v3;
    logic [N3*S-1:0] d3;
    logic [N3*W-1:0] data3;
    logic [N3-1:0]   rdy3;
    logic [N3-1:0]   ov3;
    logic [N3*W-1:0] od3;
    logic [N3*S-1:0] os3;
    logic [N3-1:0]   or3;
    logic            err3;

    int checks;
    int errors;

    crossbar_nxn_rr #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .err_drop(err_drop)
    );

    crossbar_nxn_rr #(.N(N3), .W(W)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v3), .in_dest(d3), .in_data(data3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(or3),
        .err_drop(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic v, input logic [S-1:0] d, input logic [W-1:0] x);
        in_valid[i]         = v;
        in_dest[i*S +: S]   = d;
        in_data[i*W +: W]   = x;
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_dest  = '0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_dest   = 8'b01_01_01_01;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 4'b1111;
        #3;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        checks++;
        if (out_valid !== 4'b0000 || err_drop !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got valid=%b err=%b want 0000/0", out_valid, err_drop);
        end
        step();
        step();
        clear_in();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_idle_after_release: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_single();
        clear_in();
        out_ready = 4'b1111;
        set_in(0, 1'b1, 2'd2, 8'hA5);
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready: got %b want 0001", in_ready);
        end
        step();
        clear_in();
        checks++;
        if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'hA5 || out_src[2*S +: S] !== 2'd0) begin
            errors++;
            $display("FAIL single_out: got valid=%b data=%h src=%0d want 0100/a5/0",
                     out_valid, out_data[2*W +: W], out_src[2*S +: S]);
        end
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL single_drain: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_contention();
        int exp_seq[5];
`ifdef XBAR_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        out_ready = 4'b1111;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 2'd1, 8'h40 + 8'(i));
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_seq[c])) begin
                errors++; $display("FAIL contention_ready[%0d]: got %b want %b", c, in_ready, 4'b0001 << exp_seq[c]);
            end
            step();
            checks++;
            if (out_valid !== 4'b0010 || out_src[1*S +: S] !== 2'(exp_seq[c])
                || out_data[1*W +: W] !== 8'h40 + 8'(exp_seq[c])) begin
                errors++;
                $display("FAIL contention_out[%0d]: got valid=%b src=%0d data=%h want 0010/%0d/%h", c,
                         out_valid, out_src[1*S +: S], out_data[1*W +: W], exp_seq[c], 8'h40 + 8'(exp_seq[c]));
            end
        end
        clear_in();
        step();
    endtask

    task automatic test_backpressure();
        clear_in();
        out_ready = 4'b0111;
        set_in(1, 1'b1, 2'd3, 8'h3C);
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_first_ready: got %b want 0010", in_ready);
        end
        step();
        set_in(1, 1'b1, 2'd3, 8'h77);
        set_in(0, 1'b0, 2'd3, 8'hEE);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_ready[1] !== 1'b0 || out_valid[3] !== 1'b1 || out_data[3*W +: W] !== 8'h3C
                || out_src[3*S +: S] !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy1=%b valid3=%b data3=%h src3=%0d want 0/1/3c/1", c,
                         in_ready[1], out_valid[3], out_data[3*W +: W], out_src[3*S +: S]);
            end
            set_in(0, 1'b0, 2'd3, 8'(c));
            step();
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready: got %b want 0010", in_ready);
        end
        step();
        clear_in();
        checks++;
        if (out_valid !== 4'b1000 || out_data[3*W +: W] !== 8'h77) begin
            errors++; $display("FAIL bp_refill: got valid=%b data3=%h want 1000/77", out_valid, out_data[3*W +: W]);
        end
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_drain: got %b want 0000", out_valid);
        end
    endtask

    task automatic drive_parallel();
        set_in(0, 1'b1, 2'd1, 8'h10);
        set_in(1, 1'b1, 2'd0, 8'h11);
        set_in(2, 1'b1, 2'd3, 8'h12);
        set_in(3, 1'b1, 2'd2, 8'h13);
    endtask

    task automatic test_parallel();
        out_ready = 4'b1111;
        drive_parallel();
        #1;
        checks++;
        if (in_ready !== 4'b1111) begin
            errors++; $display("FAIL parallel_ready: got %b want 1111", in_ready);
        end
        step();
        clear_in();
        checks++;
        if (out_valid !== 4'b1111 || out_data !== 32'h12_13_10_11 || out_src !== 8'b10_11_00_01) begin
            errors++;
            $display("FAIL parallel_out: got valid=%b data=%h src=%b want 1111/12131011/10110001",
                     out_valid, out_data, out_src);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        drive_parallel();
        step();
        checks++;
        if (out_valid !== 4'b1111) begin
            errors++; $display("FAIL rmid_full: got %b want 1111", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || out_data !== '0 || out_src !== '0 || err_drop !== 1'b0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_async: got valid=%b data=%h src=%b err=%b rdy=%b want all zero",
                     out_valid, out_data, out_src, err_drop, in_ready);
        end
        step();
        rst_n = 1'b1;
        out_ready = 4'b1111;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 2'd1, 8'h50 + 8'(i));
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL rmid_ptr_reset: got %b want 0001", in_ready);
        end
        step();
        clear_in();
        checks++;
        if (out_valid !== 4'b0010 || out_src[1*S +: S] !== 2'd0 || out_data[1*W +: W] !== 8'h50) begin
            errors++;
            $display("FAIL rmid_resume: got valid=%b src=%0d data=%h want 0010/0/50",
                     out_valid, out_src[1*S +: S], out_data[1*W +: W]);
        end
        step();
    endtask

    task automatic test_illegal();
        or3   = 3'b111;
        v3    = 3'b101;
        d3    = {2'd3, 2'd0, 2'd0};
        data3 = {8'h5A, 8'h00, 8'h11};
        #1;
        checks++;
        if (rdy3 !== 3'b101) begin
            errors++; $display("FAIL illegal_ready: got %b want 101", rdy3);
        end
        step();
        v3 = 3'b000;
        checks++;
        if (err3 !== 1'b1 || ov3 !== 3'b001 || od3[7:0] !== 8'h11) begin
            errors++; $display("FAIL illegal_pulse: got err=%b valid=%b data0=%h want 1/001/11", err3, ov3, od3[7:0]);
        end
        step();
        checks++;
        if (err3 !== 1'b0 || ov3 !== 3'b000) begin
            errors++; $display("FAIL illegal_clear: got err=%b valid=%b want 0/000", err3, ov3);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        v3     = '0;
        d3     = '0;
        data3  = '0;
        or3    = 3'b111;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_parallel();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
